// File: rtl/multicore_pkg.sv
// Shared types for the multicore launch controller: FSM state encoding and
// the externally visible status codes.
package multicore_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ARM  = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_END  = 2'b11;

  // DONE and FAULT share a status code; timeout tells them apart.
  function automatic logic [1:0] status_of(input state_t s);
    logic [1:0] code;
    code = ST_IDLE;
    case (s)
      S_IDLE:  code = ST_IDLE;
      S_ARM:   code = ST_ARM;
      S_RUN:   code = ST_RUN;
      S_DONE:  code = ST_END;
      S_FAULT: code = ST_END;
      default: code = ST_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module ctrl_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/multicore_launch_ctrl.sv
// Launch/completion controller: holds the core array in reset, releases it,
// gathers per-core completion and flags runs that never finish.
module multicore_launch_ctrl
  import multicore_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int HOLD_CYCLES    = 10,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 start_process,
  input  logic [NUM_CORES-1:0] active_mask,
  input  logic [NUM_CORES-1:0] end_process,
  output logic                 core_rst,
  output logic                 begin_process,
  output logic [1:0]           status,
  output logic [NUM_CORES-1:0] done_mask,
  output logic [CNT_W-1:0]     run_cycles,
  output logic                 timeout,
  output logic                 busy
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t               state;
  logic [NUM_CORES-1:0] mask_q;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 arm_entry;
  logic                 hold_en;
  logic                 run_en;
  logic [NUM_CORES-1:0] done_next;
  logic                 all_done;
  logic                 hold_last;
  logic                 wd_hit;

  always_comb begin
    arm_entry = (state == S_IDLE) && start_process;
    hold_en   = (state == S_ARM);
    run_en    = (state == S_RUN) && start_process;
    done_next = done_mask | (end_process & mask_q);
    // Cores outside the latched mask count as finished from the start.
    all_done  = &(done_next | ~mask_q);
    hold_last = (hold_cnt == HOLD_LAST);
    wd_hit    = WD_EN && (run_cycles == TO_LAST);
  end

  ctrl_sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clock  (clock),
    .rst_n  (rst_n),
    .clear  (arm_entry),
    .enable (hold_en),
    .count  (hold_cnt)
  );

  ctrl_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clock  (clock),
    .rst_n  (rst_n),
    .clear  (arm_entry),
    .enable (run_en),
    .count  (run_cycles)
  );

  assign status = status_of(state);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      mask_q        <= '0;
      done_mask     <= '0;
      core_rst      <= 1'b0;
      begin_process <= 1'b0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_process) begin
            state     <= S_ARM;
            mask_q    <= active_mask;
            done_mask <= '0;
            core_rst  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_ARM: begin
          if (!start_process) begin
            state    <= S_IDLE;
            core_rst <= 1'b0;
            busy     <= 1'b0;
          end else if (hold_last) begin
            state         <= S_RUN;
            core_rst      <= 1'b0;
            begin_process <= 1'b1;
          end
        end
        S_RUN: begin
          // An abort freezes done_mask and run_cycles at their current values.
          if (!start_process) begin
            state         <= S_IDLE;
            begin_process <= 1'b0;
            busy          <= 1'b0;
          end else begin
            done_mask <= done_next;
            if (all_done) begin
              state         <= S_DONE;
              begin_process <= 1'b0;
              busy          <= 1'b0;
            end else if (wd_hit) begin
              state         <= S_FAULT;
              begin_process <= 1'b0;
              busy          <= 1'b0;
              timeout       <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!start_process) state <= S_IDLE;
        end
        S_FAULT: begin
          if (!start_process) begin
            state   <= S_IDLE;
            timeout <= 1'b0;
          end
        end
        default: begin
          state         <= S_IDLE;
          core_rst      <= 1'b0;
          begin_process <= 1'b0;
          timeout       <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_launch_ctrl.sv
// Randomised bench for multicore_launch_ctrl: each run's outcome is predicted
// from per-core finish times, then checked cycle by cycle and at the end.
module tb_multicore_launch_ctrl;

  localparam int NC   = 4;
  localparam int HOLD = 10;
  localparam int CW   = 16;
  localparam int TO   = 50;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_process = 1'b0;
  logic [NC-1:0] active_mask = '0;
  logic [NC-1:0] end_process = '0;
  logic          core_rst, begin_process, timeout, busy;
  logic [1:0]    status;
  logic [NC-1:0] done_mask;
  logic [CW-1:0] run_cycles;

  logic       start2 = 1'b0;
  logic [0:0] mask2 = 1'b1;
  logic [0:0] end2 = 1'b0;
  logic       core_rst2, begin2, timeout2, busy2;
  logic [1:0] status2;
  logic [0:0] done2;
  logic [2:0] rc2;

  multicore_launch_ctrl #(.NUM_CORES(NC), .HOLD_CYCLES(HOLD), .CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .rst_n(rst_n), .start_process(start_process), .active_mask(active_mask),
    .end_process(end_process), .core_rst(core_rst), .begin_process(begin_process),
    .status(status), .done_mask(done_mask), .run_cycles(run_cycles), .timeout(timeout), .busy(busy)
  );

  multicore_launch_ctrl #(.NUM_CORES(1), .HOLD_CYCLES(1), .CNT_W(3), .TIMEOUT_CYCLES(0)) dut_sat (
    .clock(clock), .rst_n(rst_n), .start_process(start2), .active_mask(mask2),
    .end_process(end2), .core_rst(core_rst2), .begin_process(begin2),
    .status(status2), .done_mask(done2), .run_cycles(rc2), .timeout(timeout2), .busy(busy2)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int fin_idx[NC];
  logic [NC-1:0] last_dm;
  int last_rc;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Launch with the given mask; fin_idx[i] is the RUN cycle core i signals
  // completion (-1 = never). abort_at / reset_at interrupt RUN at that cycle.
  task automatic run_launch(input logic [NC-1:0] mask, input int abort_at, input int reset_at);
    int c, r;
    bit never, exp_fault;
    logic [NC-1:0] exp_dm, exp_pref, e;
    never = 0;
    c = 0;
    for (int i = 0; i < NC; i++) begin
      if (mask[i]) begin
        if (fin_idx[i] < 0) never = 1;
        else if (fin_idx[i] > c) c = fin_idx[i];
      end
    end
    exp_dm = '0;
    if (never || c > TO - 1) begin
      exp_fault = 1;
      last_rc = TO;
      for (int i = 0; i < NC; i++)
        if (mask[i] && fin_idx[i] >= 0 && fin_idx[i] <= TO - 1) exp_dm[i] = 1'b1;
    end else begin
      exp_fault = 0;
      last_rc = c + 1;
      exp_dm = mask;
    end
    last_dm = exp_dm;

    active_mask = mask;
    start_process = 1'b1;
    end_process = NC'($urandom);
    tick;
    checks++; if ({status, core_rst, busy, begin_process} !== 5'b01110) begin failures++; $display("FAIL arm_entry got=%b exp=01110", {status, core_rst, busy, begin_process}); end
    checks++; if (done_mask !== '0 || run_cycles !== '0) begin failures++; $display("FAIL arm_clear dm=%b rc=%0d exp 0/0", done_mask, run_cycles); end
    active_mask = NC'($urandom);
    for (int k = 2; k <= HOLD; k++) begin
      tick;
      checks++; if ({status, core_rst, begin_process} !== 4'b0110) begin failures++; $display("FAIL arm_hold k=%0d got=%b exp=0110", k, {status, core_rst, begin_process}); end
    end
    tick;
    r = 0;
    while (status === 2'b10 && r < 200) begin
      exp_pref = '0;
      for (int i = 0; i < NC; i++)
        if (mask[i] && fin_idx[i] >= 0 && fin_idx[i] < r) exp_pref[i] = 1'b1;
      checks++; if ({begin_process, core_rst, busy} !== 3'b101) begin failures++; $display("FAIL run_outs r=%0d got=%b exp=101", r, {begin_process, core_rst, busy}); end
      checks++; if (run_cycles !== CW'(r)) begin failures++; $display("FAIL run_count got=%0d exp=%0d", run_cycles, r); end
      checks++; if (done_mask !== exp_pref) begin failures++; $display("FAIL run_done_mask r=%0d got=%b exp=%b", r, done_mask, exp_pref); end
      if (r == abort_at) begin
        start_process = 1'b0;
        end_process = '0;
        tick;
        checks++; if ({status, begin_process, busy, core_rst} !== 5'b00000) begin failures++; $display("FAIL abort_idle got=%b exp=00000", {status, begin_process, busy, core_rst}); end
        checks++; if (done_mask !== exp_pref || run_cycles !== CW'(r)) begin failures++; $display("FAIL abort_hold dm=%b rc=%0d exp %b/%0d", done_mask, run_cycles, exp_pref, r); end
        return;
      end
      if (r == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({core_rst, begin_process, busy, timeout, status} !== 6'b0) begin failures++; $display("FAIL async_rst_outs got=%b exp=000000", {core_rst, begin_process, busy, timeout, status}); end
        checks++; if (done_mask !== '0 || run_cycles !== '0) begin failures++; $display("FAIL async_rst_regs dm=%b rc=%0d exp 0/0", done_mask, run_cycles); end
        start_process = 1'b0;
        end_process = '0;
        rst_n = 1'b1;
        tick;
        checks++; if ({status, core_rst, begin_process} !== 4'b0000) begin failures++; $display("FAIL async_rst_idle got=%b exp=0000", {status, core_rst, begin_process}); end
        return;
      end
      e = NC'($urandom);
      for (int i = 0; i < NC; i++) begin
        if (mask[i]) begin
          if (fin_idx[i] < 0 || r < fin_idx[i]) e[i] = 1'b0;
          else if (r == fin_idx[i]) e[i] = 1'b1;
        end
      end
      end_process = e;
      tick;
      r++;
    end
    end_process = '0;
    checks++; if (r !== last_rc) begin failures++; $display("FAIL run_length got=%0d exp=%0d", r, last_rc); end
    checks++; if ({status, timeout} !== {2'b11, exp_fault}) begin failures++; $display("FAIL end_status got=%b exp=%b", {status, timeout}, {2'b11, exp_fault}); end
    checks++; if (done_mask !== exp_dm) begin failures++; $display("FAIL end_done_mask got=%b exp=%b", done_mask, exp_dm); end
    checks++; if (run_cycles !== CW'(last_rc)) begin failures++; $display("FAIL end_run_cycles got=%0d exp=%0d", run_cycles, last_rc); end
    checks++; if ({begin_process, busy, core_rst} !== 3'b000) begin failures++; $display("FAIL end_outs got=%b exp=000", {begin_process, busy, core_rst}); end
  endtask

  task automatic release_idle;
    start_process = 1'b0;
    tick;
    checks++; if ({status, timeout, busy} !== 4'b0000) begin failures++; $display("FAIL release got=%b exp=0000", {status, timeout, busy}); end
    checks++; if (done_mask !== last_dm || run_cycles !== CW'(last_rc)) begin failures++; $display("FAIL release_hold dm=%b rc=%0d exp %b/%0d", done_mask, run_cycles, last_dm, last_rc); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if ({core_rst, begin_process, timeout, busy, status} !== 6'b0) begin failures++; $display("FAIL reset_outs got=%b exp=000000", {core_rst, begin_process, timeout, busy, status}); end
    checks++; if (done_mask !== '0 || run_cycles !== '0) begin failures++; $display("FAIL reset_regs dm=%b rc=%0d exp 0/0", done_mask, run_cycles); end
    @(negedge clock);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_nominal;
    fin_idx = '{5, 20, 9, 30};
    run_launch(4'b1111, -1, -1);
    checks++; if (run_cycles !== 16'd31) begin failures++; $display("FAIL nominal_rc got=%0d exp=31", run_cycles); end
  endtask

  task automatic test_relaunch_gating;
    for (int k = 0; k < 20; k++) begin
      tick;
      checks++; if (status !== 2'b11 || done_mask !== 4'b1111) begin failures++; $display("FAIL gate_hold k=%0d st=%b dm=%b exp 11/1111", k, status, done_mask); end
    end
    start_process = 1'b0;
    tick;
    checks++; if (status !== 2'b00) begin failures++; $display("FAIL gate_drop got=%b exp=00", status); end
    start_process = 1'b1;
    tick;
    checks++; if ({status, core_rst} !== 3'b011 || done_mask !== '0 || run_cycles !== '0) begin failures++; $display("FAIL gate_rearm st=%b dm=%b rc=%0d", status, done_mask, run_cycles); end
    start_process = 1'b0;
    tick;
  endtask

  task automatic test_early_abort;
    active_mask = 4'b1111;
    start_process = 1'b1;
    tick;
    for (int k = 2; k <= 4; k++) tick;
    checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL abort_pre got=%b exp=1", core_rst); end
    start_process = 1'b0;
    tick;
    checks++; if ({status, core_rst, busy} !== 4'b0000) begin failures++; $display("FAIL abort_arm got=%b exp=0000", {status, core_rst, busy}); end
    for (int k = 0; k < 15; k++) begin
      tick;
      checks++; if (begin_process !== 1'b0) begin failures++; $display("FAIL abort_begin got=%b exp=0", begin_process); end
    end
  endtask

  task automatic test_partial;
    fin_idx = '{$urandom_range(0, 20), -1, $urandom_range(0, 20), -1};
    run_launch(4'b0101, -1, -1);
    release_idle();
    fin_idx = '{-1, -1, -1, -1};
    run_launch(4'b0000, -1, -1);
    checks++; if (run_cycles !== 16'd1) begin failures++; $display("FAIL zero_mask_rc got=%0d exp=1", run_cycles); end
    release_idle();
  endtask

  task automatic test_watchdog;
    fin_idx = '{3, 10, 7, -1};
    run_launch(4'b1111, -1, -1);
    checks++; if (timeout !== 1'b1 || done_mask !== 4'b0111) begin failures++; $display("FAIL wd_fault to=%b dm=%b exp 1/0111", timeout, done_mask); end
    release_idle();
    fin_idx = '{0, 12, 40, 49};
    run_launch(4'b1111, -1, -1);
    checks++; if (timeout !== 1'b0 || status !== 2'b11) begin failures++; $display("FAIL wd_edge to=%b st=%b exp 0/11", timeout, status); end
    release_idle();
  endtask

  task automatic test_run_abort;
    fin_idx = '{2, 6, 30, 40};
    run_launch(4'b1111, 12, -1);
    tick;
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NC; i++)
        fin_idx[i] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 60));
      run_launch(NC'($urandom), -1, -1);
      release_idle();
    end
  endtask

  task automatic test_async_reset;
    fin_idx = '{4, 8, 25, 33};
    run_launch(4'b1111, -1, 15);
  endtask

  task automatic test_saturation;
    start2 = 1'b1;
    end2 = 1'b0;
    tick;
    checks++; if ({status2, core_rst2} !== 3'b011) begin failures++; $display("FAIL sat_arm got=%b exp=011", {status2, core_rst2}); end
    tick;
    checks++; if ({status2, begin2} !== 3'b101) begin failures++; $display("FAIL sat_run got=%b exp=101", {status2, begin2}); end
    for (int k = 0; k < 12; k++) tick;
    checks++; if (rc2 !== 3'd7 || status2 !== 2'b10 || timeout2 !== 1'b0) begin failures++; $display("FAIL sat_count rc=%0d st=%b to=%b exp 7/10/0", rc2, status2, timeout2); end
    end2 = 1'b1;
    tick;
    end2 = 1'b0;
    checks++; if (status2 !== 2'b11 || rc2 !== 3'd7 || done2 !== 1'b1 || busy2 !== 1'b0) begin failures++; $display("FAIL sat_done st=%b rc=%0d dm=%b busy=%b", status2, rc2, done2, busy2); end
    start2 = 1'b0;
    tick;
    checks++; if (status2 !== 2'b00) begin failures++; $display("FAIL sat_idle got=%b exp=00", status2); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_relaunch_gating();
    test_early_abort();
    test_partial();
    test_watchdog();
    test_run_abort();
    test_random();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL sim_time_limit reached exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
